// File: rtl/hamming74_serial_encoder.sv
// Hamming(7,4) serial transmitter: it accepts a nibble over valid/ready and shifts out
// an 8-slot frame, made of the 7 codeword bits followed by one guard slot at IDLE_LEVEL.
module hamming74_serial_encoder #(
  parameter bit LSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [3:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       encode_out,
  output logic       frame_start,
  output logic       busy,
  output logic [6:0] debug_codeword_out,
  output logic [2:0] debug_counter_out
);

  typedef enum logic [1:0] {IDLE, SHIFT, GUARD} state_t;

  state_t     state, state_nx;
  logic [2:0] counter, counter_nx;
  logic [6:0] codeword, codeword_nx, codeword_in;
  logic       encode_nx, frame_start_nx, accept;

  // Layout b6..b0 = d3 d2 d1 c2 d0 c1 c0
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic c0, c1, c2;
    c0 = d[0] ^ d[1] ^ d[3];
    c1 = d[0] ^ d[2] ^ d[3];
    c2 = d[0] ^ d[1] ^ d[2];
    return {d[3], d[2], d[1], c2, d[0], c1, c0};
  endfunction

  function automatic logic slot_bit(input logic [6:0] cw, input logic [2:0] idx);
    return LSB_FIRST ? cw[idx] : cw[3'd6 - idx];
  endfunction

  assign codeword_in = encode(data_in);
  assign data_ready  = !rst && ena && (state == IDLE || state == GUARD);
  assign accept      = data_valid && data_ready;
  assign busy        = (state != IDLE);

  // NOTE: every signal gets a hold-value default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_nx       = state;
    counter_nx     = counter;
    codeword_nx    = codeword;
    encode_nx      = encode_out;
    frame_start_nx = frame_start;
    if (ena) begin
      frame_start_nx = 1'b0;
      case (state)
        SHIFT: begin
          if (counter == 3'd6) begin
            state_nx   = GUARD;
            counter_nx = 3'd7;
            encode_nx  = IDLE_LEVEL;
          end else begin
            counter_nx = counter + 3'd1;
            encode_nx  = slot_bit(codeword, counter + 3'd1);
          end
        end
        IDLE, GUARD: begin
          if (accept) begin
            state_nx       = SHIFT;
            counter_nx     = 3'd0;
            codeword_nx    = codeword_in;
            encode_nx      = slot_bit(codeword_in, 3'd0);
            frame_start_nx = 1'b1;
          end else begin
            state_nx   = IDLE;
            counter_nx = 3'd0;
            encode_nx  = IDLE_LEVEL;
          end
        end
        default: begin
          state_nx   = IDLE;
          counter_nx = 3'd0;
          encode_nx  = IDLE_LEVEL;
        end
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so all registers update together from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      counter     <= 3'd0;
      codeword    <= 7'd0;
      encode_out  <= IDLE_LEVEL;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nx;
      counter     <= counter_nx;
      codeword    <= codeword_nx;
      encode_out  <= encode_nx;
      frame_start <= frame_start_nx;
    end
  end

  assign debug_codeword_out = codeword;
  assign debug_counter_out  = counter;

endmodule

// File: tb/tb_hamming74_serial_encoder.sv
// Self-checking bench: LSB-first and MSB-first encoders share stimulus. Frames are checked
// slot by slot against a search-based code model and a brute-force single-error decoder.
module tb_hamming74_serial_encoder;

  logic       clk = 1'b0;
  logic       rst, ena, data_valid;
  logic [3:0] data_in;
  logic       ready_l, enc_l, fs_l, busy_l;
  logic       ready_m, enc_m, fs_m, busy_m;
  logic [6:0] cw_l, cw_m;
  logic [2:0] cnt_l, cnt_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hamming74_serial_encoder #(.LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .ena(ena), .data_in(data_in), .data_valid(data_valid),
    .data_ready(ready_l), .encode_out(enc_l), .frame_start(fs_l), .busy(busy_l),
    .debug_codeword_out(cw_l), .debug_counter_out(cnt_l));

  hamming74_serial_encoder #(.LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .ena(ena), .data_in(data_in), .data_valid(data_valid),
    .data_ready(ready_m), .encode_out(enc_m), .frame_start(fs_m), .busy(busy_m),
    .debug_codeword_out(cw_m), .debug_counter_out(cnt_m));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Three parity checks; a valid codeword has all of them zero.
  function automatic logic [2:0] syndrome(input logic [6:0] w);
    return {w[3] ^ w[2] ^ w[1] ^ w[0], w[5] ^ w[4] ^ w[1] ^ w[0], w[6] ^ w[4] ^ w[2] ^ w[0]};
  endfunction

  // Codeword = the unique word with the nibble in the data positions and zero syndrome.
  function automatic logic [6:0] ref_code(input logic [3:0] d);
    logic [6:0] w;
    ref_code = 7'd0;
    for (int p = 0; p < 8; p++) begin
      w = {d[3], d[2], d[1], p[2], d[0], p[1], p[0]};
      if (syndrome(w) == 3'd0) ref_code = w;
    end
  endfunction

  function automatic logic [3:0] ref_decode(input logic [6:0] w);
    logic [6:0] c, t;
    c = w;
    if (syndrome(w) != 3'd0)
      for (int i = 0; i < 7; i++) begin
        t = w ^ (7'd1 << i);
        if (syndrome(t) == 3'd0) c = t;
      end
    return {c[6], c[5], c[4], c[2]};
  endfunction

  // One full frame of nibble d; optionally freeze ena for 3 cycles at a slot and add input noise.
  task automatic frame(input logic [3:0] d, input int freeze_at, input bit noise);
    logic [6:0] exp, got_l, got_m, bad;
    exp = ref_code(d);
    got_l = 7'd0;
    got_m = 7'd0;
    data_in = d;
    data_valid = 1'b1;
    check("idle_ready", ready_l, 1'b1);
    step();
    data_valid = 1'b0;
    for (int s = 0; s < 8; s++) begin
      check("enc_lsb", enc_l, (s < 7) ? exp[s] : 1'b0);
      check("enc_msb", enc_m, (s < 7) ? exp[6 - s] : 1'b0);
      check("frame_start", fs_l, s == 0);
      check("counter", cnt_l, s);
      check("busy", busy_l, 1'b1);
      check("ready", ready_l, s == 7);
      if (s < 7) begin
        got_l[s]     = enc_l;
        got_m[6 - s] = enc_m;
      end
      if (s == freeze_at) begin
        ena = 1'b0;
        repeat (3) begin
          step();
          check("freeze_enc", enc_l, exp[s]);
          check("freeze_counter", cnt_l, s);
          check("freeze_ready", ready_l, 1'b0);
        end
        ena = 1'b1;
      end
      if (noise && s < 7) begin
        data_in = 4'($urandom);
        data_valid = 1'($urandom);
      end else begin
        data_valid = 1'b0;
      end
      step();
    end
    check("end_busy", busy_l, 1'b0);
    check("end_counter", cnt_l, 3'd0);
    check("end_enc", enc_l, 1'b0);
    check("codeword_lsb", cw_l, exp);
    check("codeword_msb", cw_m, exp);
    check("msb_order", got_m, exp);
    check("decode_clean", ref_decode(got_l), d);
    for (int i = 0; i < 7; i++) begin
      bad = got_l ^ (7'd1 << i);
      check("flip_syndrome", syndrome(bad) != 3'd0, 1'b1);
      check("flip_decode", ref_decode(bad), d);
    end
  endtask

  initial begin
    logic [6:0] ca, cb;
    logic       eb;
    rst = 1'b1; ena = 1'b1; data_valid = 1'b0; data_in = 4'd0;
    step();
    step();
    check("rst_enc", enc_l, 1'b0);
    check("rst_busy", busy_l, 1'b0);
    check("rst_counter", cnt_l, 3'd0);
    check("rst_ready", ready_l, 1'b0);
    check("rst_codeword", cw_l, 7'd0);
    check("rst_fs", fs_l, 1'b0);
    rst = 1'b0;
    ena = 1'b0;
    #1;
    check("ena_low_ready", ready_l, 1'b0);
    ena = 1'b1;
    step();

    frame(4'b1011, -1, 1'b0);
    check("cw_1011", cw_l, 7'b1010101);
    frame(4'b0001, -1, 1'b0);
    check("cw_0001", cw_m, 7'b0001111);

    for (int n = 0; n < 16; n++) frame(4'(n), -1, 1'b0);
    for (int n = 0; n < 12; n++) frame(4'($urandom), -1, 1'b1);

    frame(4'b1011, 3, 1'b0);

    // Back-to-back frames: valid stays high across the guard slot.
    ca = ref_code(4'hF);
    cb = ref_code(4'h0);
    data_in = 4'hF;
    data_valid = 1'b1;
    step();
    data_in = 4'h0;
    for (int t = 0; t < 16; t++) begin
      eb = (t % 8 == 7) ? 1'b0 : ((t < 8) ? ca[t] : cb[t - 8]);
      check("b2b_enc", enc_l, eb);
      check("b2b_fs", fs_l, (t % 8) == 0);
      if (t == 8) data_valid = 1'b0;
      step();
    end
    check("b2b_idle", busy_l, 1'b0);

    // Reset in the middle of a frame aborts it immediately.
    data_in = 4'b1011;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    #1;
    check("abort_enc", enc_l, 1'b0);
    check("abort_busy", busy_l, 1'b0);
    check("abort_counter", cnt_l, 3'd0);
    check("abort_ready", ready_l, 1'b0);
    data_valid = 1'b1;
    step();
    check("abort_hold_busy", busy_l, 1'b0);
    check("abort_hold_ready", ready_l, 1'b0);
    check("abort_hold_fs", fs_l, 1'b0);
    data_valid = 1'b0;
    rst = 1'b0;
    step();
    frame(4'b0110, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
